cpuc_max_reduce: RTL and testbench
==================================

# cpuc_max_reduce

Streaming max-reduction unit for the CPUC datapath. It consumes a frame of DATA_WIDTH words over a valid/ready input stream, delimited by a last flag. It emits one result beat per frame over a valid/ready output stream, carrying the frame maximum, the position of that maximum, and the beat count. It sits downstream of producers that need a frame-wide maximum rather than a two-operand one.

## Interface
- DATA_WIDTH, from cpuc_package, word width.
- MAX_FRAME_LEN, 256, maximum number of beats per frame that take part in the reduction.
- IDX_WIDTH, $clog2(MAX_FRAME_LEN), width of the index output.
- CNT_WIDTH, $clog2(MAX_FRAME_LEN+1), width of the count output.
- Clock  in  1  single clock. All state changes on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  DATA_WIDTH  input word.
- in_last  in  1  current beat is the final beat of the frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_max  out  DATA_WIDTH  frame maximum.
- out_idx  out  IDX_WIDTH  zero-based beat position of the first occurrence of the maximum.
- out_count  out  CNT_WIDTH  number of beats that took part in the reduction (at most MAX_FRAME_LEN).
- out_overflow  out  1  frame had more than MAX_FRAME_LEN beats.

## Operation
- FSM states:
  - S_ACC (reset state): in_ready=1, out_valid=0.
  - S_OUT: in_ready=0, out_valid=1.
- A beat is accepted when in_valid && in_ready.
- First accepted beat of a frame, tracked by a first flag that is set at reset and after each result handshake:
  - loads max=in_data, idx=0, count=1.
  - clears the overflow flag.
- Each later accepted beat with count < MAX_FRAME_LEN:
  - replaces max and sets idx=count only if in_data is strictly greater than max. Ties keep the earlier beat.
  - increments count.
- Accepted beat with count == MAX_FRAME_LEN:
  - is consumed without taking part in the reduction.
  - sets overflow sticky for the frame.
  - leaves max, idx and count unchanged.
- Comparison is signed when the package constant SIGNED_CMP==1, otherwise unsigned.
- Accepting a beat with in_last=1 updates the result registers as above, then moves S_ACC→S_OUT.
- S_OUT→S_ACC on out_valid && out_ready. The first flag is re-armed.
- out_max, out_idx, out_count and out_overflow are registered. They stay stable throughout S_OUT.
- Frames are back-to-back with no idle requirement. A single-beat frame (first beat has in_last) is legal.
- Reset values: in_ready=1 (S_ACC), out_valid=0, out_max=0, out_idx=0, out_count=0, out_overflow=0.

## Timing
- Latency: the last beat accepted at edge N gives out_valid=1 in the cycle after edge N.
- Throughput: one input beat per cycle inside a frame. There is one bubble per frame, because in_ready=0 for every S_OUT cycle, which is a minimum of 1 cycle.
- in_ready depends only on state. It has no combinational path from out_ready.
- out_valid stays high until the handshake completes. It does not drop while out_ready=0.
- Inputs arriving while in_ready=0 are not consumed. The producer must hold them.
- Reset asserted mid-frame or in S_OUT:
  - all registers clear immediately (asynchronous).
  - any partial frame is discarded.
  - the state returns to S_ACC.

## Configuration
- CPUC_MAX_REDUCE_IDX_EN defined: index register and comparison-driven index update are present, and out_idx is driven as described.
- Not defined: no index register is built, out_idx is tied to 0, and all other behaviour is unchanged.

## Structure
- cpuc_package holds:
  - the state enum t_max_reduce_state {S_ACC, S_OUT}.
  - the constant MAX_REDUCE_FRAME_LEN, which is the default for MAX_FRAME_LEN.
  - the existing DATA_WIDTH and SIGNED_CMP, which are reused.
- The macro is defined or left undefined in cpuc_macros.vh.
- One sub-module, cpuc_max_reduce_acc:
  - holds the max/idx/count/overflow registers and the signed/unsigned compare.
  - gets its load, update and clear strobes from the top-level FSM.

## Test plan
1. Unsigned build, frame 3, 9, 5 (last on 5), out_ready=1 → one cycle after the last beat: out_valid=1, out_max=9, out_idx=1, out_count=3, out_overflow=0.
2. Frame 7, 7, 2 → out_max=7, out_idx=0, because the earlier tie wins.
3. SIGNED_CMP=1, frame 0xFFFFFFFF, 0x00000001 → out_max=1, out_idx=1. Unsigned build with the same frame → out_max=0xFFFFFFFF, out_idx=0.
4. MAX_FRAME_LEN=4, frame 1, 2, 3, 4, 100, 0 (last on 0) → out_max=4, out_idx=3, out_count=4, out_overflow=1.
5. Single beat 0x55 with last, out_ready held 0 for 5 cycles → out_valid stays 1 and outputs stay stable, in_ready=0. Raising out_ready → handshake, then in_ready=1 on the next cycle. The next frame's first beat reloads max.
6. Assert Rst_n=0 after 2 beats of a frame → in_ready=1, out_valid=0, all outputs 0. A following frame 8, 4 (last) → out_max=8, out_idx=0, out_count=2, with no state left over from the aborted frame.

Source files
------------

// File: rtl/cpuc_package.sv
// rtl/cpuc_package.sv - shared CPUC datapath constants and types
// Purpose: word width, compare signedness, max-reduce frame length default and
//          the max-reduce FSM state type.
// Ports:   none (package).
package cpuc_package;

  localparam int DATA_WIDTH           = 32;
  // 1: signed two's-complement compare, 0: unsigned compare.
  localparam int SIGNED_CMP           = 0;
  localparam int MAX_REDUCE_FRAME_LEN = 256;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } t_max_reduce_state;

endpackage

// File: rtl/cpuc_max_reduce_acc.sv
// rtl/cpuc_max_reduce_acc.sv - max/idx/count/overflow accumulator for cpuc_max_reduce
// Purpose: holds the running frame maximum, its position, the beat count and the
//          sticky overflow flag; performs the signed/unsigned compare.
// Ports:   clk, rst_n (async active-low); load (first beat of frame), update
//          (later beat of frame), in_data; out_max, out_idx, out_count, out_overflow.
// Config:  CPUC_MAX_REDUCE_IDX_EN builds the index register; otherwise out_idx is 0.
module cpuc_max_reduce_acc
  import cpuc_package::*;
#(
  parameter int MAX_FRAME_LEN = MAX_REDUCE_FRAME_LEN,
  parameter int IDX_WIDTH     = $clog2(MAX_FRAME_LEN),
  parameter int CNT_WIDTH     = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_overflow
);

  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  gt;
  logic                  full;

  always_comb begin
    gt = 1'b0;
    if (SIGNED_CMP == 1) gt = $signed(in_data) > $signed(max_q);
    else                 gt = in_data > max_q;
  end

  // Beats past MAX_FRAME_LEN are swallowed and only flag overflow.
  assign full = (count_q == CNT_WIDTH'(MAX_FRAME_LEN));

  always_comb begin
    max_d   = max_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load) begin
      max_d   = in_data;
      count_d = CNT_WIDTH'(1);
      ovf_d   = 1'b0;
    end else if (update) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        if (gt) max_d = in_data;
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      max_q   <= max_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CPUC_MAX_REDUCE_IDX_EN
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (update && !full && gt) begin
      // count < MAX_FRAME_LEN here, so it fits in IDX_WIDTH.
      idx_d = count_q[IDX_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign out_idx = idx_q;
`else
  assign out_idx = '0;
`endif

  assign out_max      = max_q;
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

endmodule

// File: rtl/cpuc_max_reduce.sv
// rtl/cpuc_max_reduce.sv - streaming frame max-reduction unit
// Purpose: consumes a last-delimited frame of words and emits one result beat
//          (max, index of first max, beat count, overflow) per frame.
// Ports:   clk, rst_n (async active-low); in_valid/in_ready/in_data/in_last input
//          stream; out_valid/out_ready/out_max/out_idx/out_count/out_overflow result.
// Config:  CPUC_MAX_REDUCE_IDX_EN enables the index tracking (else out_idx = 0).
module cpuc_max_reduce
  import cpuc_package::*;
#(
  parameter int MAX_FRAME_LEN = MAX_REDUCE_FRAME_LEN,
  parameter int IDX_WIDTH     = $clog2(MAX_FRAME_LEN),
  parameter int CNT_WIDTH     = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_overflow
);

  t_max_reduce_state state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic first_q, first_d;
  logic accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          first_d = 1'b0;
          if (in_last) begin
            state_d     = S_OUT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          first_d     = 1'b1;
        end
      end
      default: begin
        state_d     = S_ACC;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        first_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  cpuc_max_reduce_acc #(
    .MAX_FRAME_LEN (MAX_FRAME_LEN),
    .IDX_WIDTH     (IDX_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept && first_q),
    .update       (accept && !first_q),
    .in_data      (in_data),
    .out_max      (out_max),
    .out_idx      (out_idx),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

endmodule

// File: tb/tb_cpuc_max_reduce.sv
// tb/tb_cpuc_max_reduce.sv - directed self-checking bench for cpuc_max_reduce
module tb_cpuc_max_reduce;

  localparam int MFL = 4;
  localparam int IW  = 2;
  localparam int CW  = 3;
`ifdef CPUC_MAX_REDUCE_IDX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_max;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cpuc_max_reduce #(.MAX_FRAME_LEN(MFL), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  function automatic logic [IW-1:0] exp_idx(input int v);
    return IDX_EN ? IW'(v) : '0;
  endfunction

  // Present one beat at a negedge, hold until in_ready, let the next posedge take it.
  task automatic send(input logic [31:0] d, input logic last);
    int waitc;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
  endtask

  // Drop in_valid at the negedge after the last beat; out_valid must already be up.
  task automatic end_frame();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: ready/valid=%b required=10", {in_ready, out_valid}); else pass_cnt++;
    total_cnt++; if ({out_max, out_idx, out_count, out_overflow} !== '0) $display("FAIL reset_out: max=%h idx=%0d cnt=%0d ovf=%b required all 0", out_max, out_idx, out_count, out_overflow); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(32'd3, 1'b0); send(32'd9, 1'b0); send(32'd5, 1'b1);
    end_frame();
    total_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL basic_latency: valid/ready=%b required=10", {out_valid, in_ready}); else pass_cnt++;
    total_cnt++; if (out_max !== 32'd9) $display("FAIL basic_max: got=%0d required=9", out_max); else pass_cnt++;
    total_cnt++; if (out_idx !== exp_idx(1)) $display("FAIL basic_idx: got=%0d required=%0d", out_idx, exp_idx(1)); else pass_cnt++;
    total_cnt++; if ({out_count, out_overflow} !== {3'd3, 1'b0}) $display("FAIL basic_cnt: cnt=%0d ovf=%b required 3/0", out_count, out_overflow); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_handshake: valid/ready=%b required=01", {out_valid, in_ready}); else pass_cnt++;
  endtask

  task automatic test_overflow();
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0);
    send(32'd4, 1'b0); send(32'd100, 1'b0); send(32'd0, 1'b1);
    end_frame();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got=%b required=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_max !== 32'd4) $display("FAIL ovf_max: got=%0d required=4", out_max); else pass_cnt++;
    total_cnt++; if (out_idx !== exp_idx(3)) $display("FAIL ovf_idx: got=%0d required=%0d", out_idx, exp_idx(3)); else pass_cnt++;
    total_cnt++; if ({out_count, out_overflow} !== {3'd4, 1'b1}) $display("FAIL ovf_cnt: cnt=%0d ovf=%b required 4/1", out_count, out_overflow); else pass_cnt++;
  endtask

  // Tie frame sent straight after the overflow result: beat waits out the S_OUT bubble.
  task automatic test_back_to_back();
    send(32'd7, 1'b0); send(32'd7, 1'b0); send(32'd2, 1'b1);
    end_frame();
    total_cnt++; if ({out_valid, out_max} !== {1'b1, 32'd7}) $display("FAIL tie_max: valid=%b max=%0d required 1/7", out_valid, out_max); else pass_cnt++;
    total_cnt++; if (out_idx !== exp_idx(0)) $display("FAIL tie_idx: got=%0d required=%0d", out_idx, exp_idx(0)); else pass_cnt++;
    total_cnt++; if ({out_count, out_overflow} !== {3'd3, 1'b0}) $display("FAIL tie_cnt: cnt=%0d ovf=%b required 3/0", out_count, out_overflow); else pass_cnt++;
  endtask

  task automatic test_sign();
    logic [31:0] em;
    int ei;
    em = (cpuc_package::SIGNED_CMP == 1) ? 32'd1 : 32'hFFFF_FFFF;
    ei = (cpuc_package::SIGNED_CMP == 1) ? 1 : 0;
    send(32'hFFFF_FFFF, 1'b0); send(32'h0000_0001, 1'b1);
    end_frame();
    total_cnt++; if (out_max !== em) $display("FAIL sign_max: got=%h required=%h", out_max, em); else pass_cnt++;
    total_cnt++; if (out_idx !== exp_idx(ei)) $display("FAIL sign_idx: got=%0d required=%0d", out_idx, exp_idx(ei)); else pass_cnt++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h55, 1'b1);
    end_frame();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, out_max, out_count} !== {1'b1, 1'b0, 32'h55, 3'd1})
        $display("FAIL stall_hold%0d: valid=%b ready=%b max=%h cnt=%0d required 1/0/55/1", i, out_valid, in_ready, out_max, out_count);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_release: valid/ready=%b required=01", {out_valid, in_ready}); else pass_cnt++;
    send(32'd2, 1'b0); send(32'd1, 1'b1);
    end_frame();
    total_cnt++; if ({out_max, out_count} !== {32'd2, 3'd2}) $display("FAIL stall_reload: max=%h cnt=%0d required 2/2", out_max, out_count); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    send(32'd10, 1'b0); send(32'd20, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_mid_hs: ready/valid=%b required=10", {in_ready, out_valid}); else pass_cnt++;
    total_cnt++; if ({out_max, out_idx, out_count, out_overflow} !== '0) $display("FAIL rst_mid_out: max=%h idx=%0d cnt=%0d ovf=%b required all 0", out_max, out_idx, out_count, out_overflow); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd8, 1'b0); send(32'd4, 1'b1);
    end_frame();
    total_cnt++; if ({out_valid, out_max, out_count, out_overflow} !== {1'b1, 32'd8, 3'd2, 1'b0}) $display("FAIL rst_mid_frame: valid=%b max=%0d cnt=%0d ovf=%b required 1/8/2/0", out_valid, out_max, out_count, out_overflow); else pass_cnt++;
    total_cnt++; if (out_idx !== exp_idx(0)) $display("FAIL rst_mid_idx: got=%0d required=%0d", out_idx, exp_idx(0)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_sign();
    test_stall();
    test_reset_midframe();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
